// File: rtl/d_cache_pkg.sv
`default_nettype none
// =============================================================================
// d_cache_pkg : shared line geometry and FSM encoding for d_cache.  Rev 1.0
// =============================================================================
package d_cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_BITS  = 32;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/d_cache.sv
`default_nettype none
// =============================================================================
// d_cache : direct-mapped write-back, write-allocate data cache, 4-word lines.
// Optional macro D_CACHE_PERF_EN adds hit_cnt/miss_cnt outputs.  Rev 1.0
// =============================================================================
module d_cache
  import d_cache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 proc_ren,
  input  logic                 proc_wen,
  input  logic [29:0]          proc_addr,
  input  logic [31:0]          proc_wdata,
  output logic [31:0]          proc_rdata,
  output logic                 proc_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [27:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
`ifdef D_CACHE_PERF_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_LINES-1:0]   r_valid;
  logic [NUM_LINES-1:0]   r_dirty;
  logic [TW-1:0]          r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0]   r_data [NUM_LINES];

  logic [1:0]             w_off;
  logic [IW-1:0]          w_index;
  logic [TW-1:0]          w_tag;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_wr_hit;
  logic                   w_fill;
  logic [LINE_BITS-1:0]   w_line;

  assign w_off    = proc_addr[1:0];
  assign w_index  = proc_addr[IW+1:2];
  assign w_tag    = proc_addr[29:IW+2];
  assign w_req    = proc_ren | proc_wen;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line   = r_data[w_index];
  // A simultaneous read+write request is handled purely as a write.
  assign w_wr_hit = (r_state == ST_IDLE) && proc_wen && w_hit;
  assign w_fill   = (r_state == ST_ALLOCATE) && mem_ready;

  assign proc_rdata = w_line[{w_off, 5'd0} +: WORD_BITS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_hit) begin
        r_dirty[w_index] <= 1'b1;
      end else if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_wr_hit) begin
        r_data[w_index][{w_off, 5'd0} +: WORD_BITS] <= proc_wdata;
      end else if (w_fill) begin
        r_data[w_index] <= mem_rdata;
        r_tag[w_index]  <= w_tag;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    proc_stall  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = proc_addr[29:2];
    mem_wdata   = w_line;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !w_hit) begin
          proc_stall  = 1'b1;
          w_state_nxt = (r_valid[w_index] && r_dirty[w_index]) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {r_tag[w_index], w_index};
        if (mem_ready) begin
          w_state_nxt = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef D_CACHE_PERF_EN
  logic        r_refilled;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // The completion right after a refill is the tail of a miss, not a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refilled <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_refilled <= w_fill;
      if (r_state == ST_IDLE && w_req) begin
        if (!w_hit) begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end else if (!r_refilled) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_cache.sv
`default_nettype none
// =============================================================================
// tb_d_cache : randomized scoreboard bench for d_cache against a flat-memory
// reference model with a latency-randomized block memory responder.  Rev 1.0
// =============================================================================
module tb_d_cache;

  localparam int NL      = 8;
  localparam int TIMEOUT = 60;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_ren, proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef D_CACHE_PERF_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  d_cache #(.NUM_LINES(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef D_CACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a flat word-addressed memory the processor sees through the cache.
  logic [31:0] ref_mem [logic [29:0]];
  // Backing store behind the cache, written only by block writebacks.
  logic [31:0] bmem    [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [29:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  // Which block is resident at each index (abstract direct-mapped placement).
  bit          res_v [NL];
  logic [27:0] res_b [NL];

  typedef struct { logic [29:0] addr; logic [31:0] data; } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  // Memory responder: mem_ready pulses cur_lat cycles after a transfer starts.
  int           lat_cfg = 3;
  int           cur_lat = 0;
  int           busy    = 0;
  bit           started = 1'b0;
  logic [27:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [127:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      started   = 1'b0;
      busy      = 0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        started   = 1'b0;
      end
      if (mem_read || mem_write) begin
        chk("rd_wr_exclusive", {126'd0, mem_read, mem_write} == 128'd3, 128'd0);
        if (!started) begin
          started = 1'b1;
          busy    = 0;
          cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        end
        if (busy == cur_lat) begin
          if (mem_write) begin
            for (int i = 0; i < 4; i++) bmem[{mem_addr, 2'(i)}] = mem_wdata[32*i +: 32];
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
          end else begin
            for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = bmem_rd({mem_addr, 2'(i)});
            last_rd_addr = mem_addr;
          end
          mem_ready = 1'b1;
        end else begin
          busy++;
        end
      end
    end
  end

  // Monitor: every completed pure read is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && proc_ren && !proc_wen && !proc_stall) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 128'd1, 128'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rd_addr", {98'd0, proc_addr}, {98'd0, sb_e.addr});
        chk("rdata", {96'd0, proc_rdata}, {96'd0, sb_e.data});
      end
    end
  end

  task automatic do_req(input logic r, input logic w, input logic [29:0] a,
                        input logic [31:0] d, output int stalls);
    logic [27:0] blk;
    int          idx;
    bit          exp_hit;
    blk     = a[29:2];
    idx     = int'(blk % NL);
    exp_hit = res_v[idx] && (res_b[idx] == blk);
    if (r && !w) sb_q.push_back('{addr: a, data: ref_rd(a)});
    proc_ren   = r;
    proc_wen   = w;
    proc_addr  = a;
    proc_wdata = d;
    stalls     = 0;
    @(negedge clk);
    while (proc_stall && stalls < TIMEOUT) begin
      stalls++;
      @(negedge clk);
    end
    if (proc_stall) chk("req_timeout", 128'd1, 128'd0);
    if (exp_hit) chk("hit_no_stall", 128'(stalls), 128'd0);
    else         chk("miss_stalls", {127'd0, stalls >= 2}, 128'd1);
    if (w) ref_mem[a] = d;
    res_v[idx] = 1'b1;
    res_b[idx] = blk;
    @(posedge clk); #1;
    proc_ren = 1'b0;
    proc_wen = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_stall", {127'd0, proc_stall}, 128'd0);
    chk("idle_mem", {126'd0, mem_read, mem_write}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int guard;
    logic [29:0] a;
    int k;

    rst_n = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = '0; proc_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      bmem[30'h10 + 30'(i)]    = 32'hA + 32'(i);
      ref_mem[30'h10 + 30'(i)] = 32'hA + 32'(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {127'd0, proc_stall}, 128'd0);
    chk("reset_mem", {126'd0, mem_read, mem_write}, 128'd0);
`ifdef D_CACHE_PERF_EN
    chk("reset_cnts", {64'd0, hit_cnt, miss_cnt}, 128'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    // Cold read, memory answers 3 cycles after the request appears.
    lat_cfg = 3;
    do_req(1'b1, 1'b0, 30'h10, 32'h0, st);
    chk("cold_stalls", 128'(st), 128'd5);
    chk("cold_mem_addr", {100'd0, last_rd_addr}, 128'h4);

    do_req(1'b0, 1'b1, 30'h11, 32'hCAFEBABE, st);
    chk("wr_hit_stalls", 128'(st), 128'd0);
    do_req(1'b1, 1'b0, 30'h11, 32'h0, st);
    chk("rd_hit_stalls", 128'(st), 128'd0);

    // Dirty conflict on index 4: writeback of the modified line, then refill.
    do_req(1'b1, 1'b0, 30'h30, 32'h0, st);
    chk("dirty_stalls", 128'(st), 128'd9);
    chk("wb_addr", {100'd0, last_wr_addr}, 128'h4);
    chk("wb_data", last_wr_data, 128'h0000000D_0000000C_CAFEBABE_0000000A);
    chk("alloc_addr", {100'd0, last_rd_addr}, 128'hC);

    do_req(1'b1, 1'b1, 30'h30, 32'h12345678, st);
    chk("rw_hit_stalls", 128'(st), 128'd0);
    do_req(1'b1, 1'b0, 30'h30, 32'h0, st);

    // Reset while the refill for 0x50 is in flight.
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h50;
    guard = 0;
    @(negedge clk);
    while (!mem_read && guard < TIMEOUT) begin
      guard++;
      @(negedge clk);
    end
    chk("alloc_reached", {127'd0, mem_read}, 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; proc_ren = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_alloc_mem", {126'd0, mem_read, mem_write}, 128'd0);
    chk("rst_alloc_stall", {127'd0, proc_stall}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NL; i++) res_v[i] = 1'b0;
    do_req(1'b1, 1'b0, 30'h50, 32'h0, st);
    chk("rst_reread_stalls", 128'(st), 128'd5);
    for (int i = 1; i < 4; i++) do_req(1'b1, 1'b0, 30'h50 + 30'(i), 32'h0, st);
`ifdef D_CACHE_PERF_EN
    chk("perf_hit_cnt", {96'd0, hit_cnt}, 128'd3);
    chk("perf_miss_cnt", {96'd0, miss_cnt}, 128'd1);
`endif

    lat_cfg = -1;
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      a = 30'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a[29] = 1'b1;
      if (k == 0)      idle_cycle();
      else if (k == 1) do_req(1'b1, 1'b1, a, $urandom, st);
      else if (k < 5)  do_req(1'b0, 1'b1, a, $urandom, st);
      else             do_req(1'b1, 1'b0, a, 32'h0, st);
    end

    idle_cycle();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
